// File: rtl/bus_assembler_if.sv
// Register-bus receive interface.
// Groups the beat/strobe inputs and the committed-value outputs of bus_assembler.
//   i_bus    beat data (BUS_W)      i_load   capture strobe
//   i_abort  drop partial beats     i_inc    increment committed value
//   i_dec    decrement committed    o_q      committed value (WIDTH)
//   o_busy   partial beats staged   o_wrap   inc/dec wrap pulse
interface bus_assembler_if #(
  parameter int WIDTH = 16,
  parameter int BUS_W = 8
);
  logic [BUS_W-1:0] i_bus;
  logic             i_load;
  logic             i_abort;
  logic             i_inc;
  logic             i_dec;
  logic [WIDTH-1:0] o_q;
  logic             o_busy;
  logic             o_wrap;

  modport master (
    output i_bus, i_load, i_abort, i_inc, i_dec,
    input  o_q, o_busy, o_wrap
  );

  modport slave (
    input  i_bus, i_load, i_abort, i_inc, i_dec,
    output o_q, o_busy, o_wrap
  );
endinterface

// File: rtl/bus_assembler.sv
// bus_assembler: assembles successive BUS_W-bit beats (little-endian) into a
// WIDTH-bit register that is committed atomically on the final beat, so
// consumers reading o_q never observe a partially updated value. The committed
// value can also be incremented/decremented in place.
// Ports:
//   i_clk    clock, all state on rising edge
//   i_reset  synchronous active-high reset
//   bus      bus_assembler_if.slave (beats, strobes, o_q/o_busy/o_wrap)
// WIDTH must be an integer multiple of BUS_W.
//
// state   | meaning
// IDLE    | no beats staged (cnt == 0)
// COLLECT | at least one beat staged, awaiting final beat (cnt > 0)
module bus_assembler #(
  parameter int               WIDTH   = 16,
  parameter int               BUS_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'('hffff)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  bus_assembler_if.slave  bus
);
  localparam int BEATS = WIDTH / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] stg_q;
  logic [WIDTH-1:0] stg_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] commit_val;
  logic             wrap_q;
  logic             last_beat;
  logic             commit;

  assign last_beat = (cnt_q == LAST_CNT);
  // Abort beats a simultaneous load, so a discarded final beat is no commit.
  assign commit    = bus.i_load & ~bus.i_abort & last_beat;

  always_comb begin
    stg_d = stg_q;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_q == CNT_W'(b)) stg_d[b*BUS_W +: BUS_W] = bus.i_bus;
    end
    // Final beat always lands in the top slice; lower slices come from staging.
    commit_val = stg_q;
    commit_val[WIDTH-1 -: BUS_W] = bus.i_bus;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stg_q   <= RST_VAL;
      q_q     <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.i_abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (bus.i_load) begin
        if (last_beat) begin
          q_q     <= commit_val;
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          stg_q   <= stg_d;
          state_q <= COLLECT;
          cnt_q   <= cnt_q + 1'b1;
        end
      end
      // inc and dec together cancel; a commit in the same cycle drops both.
      if (!commit && (bus.i_inc ^ bus.i_dec)) begin
        if (bus.i_inc) begin
          q_q    <= q_q + 1'b1;
          wrap_q <= &q_q;
        end else begin
          q_q    <= q_q - 1'b1;
          wrap_q <= ~|q_q;
        end
      end
    end
  end

  assign bus.o_q    = q_q;
  assign bus.o_busy = (state_q == COLLECT);
  assign bus.o_wrap = wrap_q;
endmodule

// File: tb/tb_bus_assembler.sv
module tb_bus_assembler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_assembler_if #(.WIDTH(16), .BUS_W(8)) bif ();
  bus_assembler_if #(.WIDTH(8),  .BUS_W(8)) sif ();

  bus_assembler #(.WIDTH(16), .BUS_W(8), .RST_VAL(16'hffff)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bif)
  );
  bus_assembler #(.WIDTH(8), .BUS_W(8), .RST_VAL(8'ha5)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(sif)
  );

  typedef struct {
    logic        rst;
    logic        load;
    logic [7:0]  data;
    logic        abort;
    logic        inc;
    logic        dec;
    logic [15:0] exp_q;
    logic        exp_busy;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  function automatic void add(logic r, logic l, logic [7:0] d, logic a, logic i, logic dc,
                              logic [15:0] q, logic b, logic w);
    vec_t v;
    v.rst = r; v.load = l; v.data = d; v.abort = a; v.inc = i; v.dec = dc;
    v.exp_q = q; v.exp_busy = b; v.exp_wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic l, logic [7:0] d, logic a, logic i, logic dc);
    rst = r;
    bif.i_load = l; bif.i_bus = d; bif.i_abort = a; bif.i_inc = i; bif.i_dec = dc;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.i_load = 1'b0; bif.i_abort = 1'b0; bif.i_inc = 1'b0; bif.i_dec = 1'b0;
  endtask

  task automatic drive1(logic l, logic [7:0] d, logic i, logic dc);
    sif.i_load = l; sif.i_bus = d; sif.i_inc = i; sif.i_dec = dc;
    @(posedge clk);
    #1;
    sif.i_load = 1'b0; sif.i_inc = 1'b0; sif.i_dec = 1'b0;
  endtask

  initial begin
    //   rst load data  abort inc dec  exp_q    busy wrap
    add(1, 1, 8'h12, 0, 0, 0, 16'hffff, 0, 0); // reset overrides load
    add(0, 1, 8'h34, 0, 0, 0, 16'hffff, 1, 0);
    add(0, 1, 8'h12, 0, 0, 0, 16'h1234, 0, 0);
    add(0, 1, 8'haa, 0, 0, 0, 16'h1234, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 16'h1234, 0, 0); // abort drops AA
    add(0, 1, 8'h78, 0, 0, 0, 16'h1234, 1, 0);
    add(0, 1, 8'h56, 0, 0, 0, 16'h5678, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h5679, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 16'h5678, 0, 0);
    add(0, 1, 8'hff, 0, 0, 0, 16'h5678, 1, 0);
    add(0, 1, 8'hff, 0, 0, 0, 16'hffff, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h0000, 0, 1); // wrap up
    add(0, 0, 8'h00, 0, 0, 0, 16'h0000, 0, 0); // pulse is one cycle
    add(0, 0, 8'h00, 0, 0, 1, 16'hffff, 0, 1); // wrap down
    add(0, 0, 8'h00, 0, 0, 0, 16'hffff, 0, 0);
    add(0, 1, 8'h10, 0, 0, 0, 16'hffff, 1, 0);
    add(0, 1, 8'h00, 0, 0, 0, 16'h0010, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 16'h0010, 1, 0);
    add(0, 1, 8'h20, 0, 1, 0, 16'h2000, 0, 0); // commit beats inc
    add(0, 0, 8'h00, 0, 1, 1, 16'h2000, 0, 0); // inc+dec cancel
    add(0, 1, 8'h11, 0, 0, 0, 16'h2000, 1, 0);
    add(0, 1, 8'h22, 1, 0, 0, 16'h2000, 0, 0); // abort beats load
    add(0, 1, 8'h33, 0, 0, 0, 16'h2000, 1, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h2001, 1, 0); // inc mid-assembly
    add(0, 1, 8'h44, 0, 0, 0, 16'h4433, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 16'h4432, 0, 0);
    add(0, 1, 8'h00, 0, 0, 0, 16'h4432, 1, 0);
    add(0, 1, 8'hff, 0, 1, 0, 16'hff00, 0, 0); // commit beats inc, no wrap

    bif.i_bus = '0; bif.i_load = 0; bif.i_abort = 0; bif.i_inc = 0; bif.i_dec = 0;
    sif.i_bus = '0; sif.i_load = 0; sif.i_abort = 0; sif.i_inc = 0; sif.i_dec = 0;
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].load, vecs[k].data, vecs[k].abort, vecs[k].inc, vecs[k].dec);
      check($sformatf("vec%0d_q", k),    bif.o_q,           vecs[k].exp_q);
      check($sformatf("vec%0d_busy", k), {15'd0, bif.o_busy}, {15'd0, vecs[k].exp_busy});
      check($sformatf("vec%0d_wrap", k), {15'd0, bif.o_wrap}, {15'd0, vecs[k].exp_wrap});
    end

    // Mid-assembly reset discards the staged beat and restores RST_VAL.
    drive(0, 1, 8'h99, 0, 0, 0);
    check("midrst_busy_before", {15'd0, bif.o_busy}, 16'd1);
    drive(1, 0, 8'h00, 0, 0, 0);
    check("midrst_busy_after", {15'd0, bif.o_busy}, 16'd0);
    check("midrst_q_after", bif.o_q, 16'hffff);
    drive(0, 1, 8'h01, 0, 0, 0);
    check("midrst_q_beat1", bif.o_q, 16'hffff);
    drive(0, 1, 8'h02, 0, 0, 0);
    check("midrst_q_final", bif.o_q, 16'h0201);
    check("midrst_busy_final", {15'd0, bif.o_busy}, 16'd0);

    // Single-beat instance: every load commits, never busy. Its reset was
    // applied by the first table vector.
    check("b1_q_reset", {8'd0, sif.o_q}, 16'h00a5);
    drive1(1, 8'h3c, 0, 0);
    check("b1_q_load", {8'd0, sif.o_q}, 16'h003c);
    check("b1_busy_load", {15'd0, sif.o_busy}, 16'd0);
    drive1(0, 8'h00, 1, 0);
    check("b1_q_inc", {8'd0, sif.o_q}, 16'h003d);
    drive1(1, 8'hff, 1, 0);
    check("b1_q_commit_inc", {8'd0, sif.o_q}, 16'h00ff);
    check("b1_wrap_commit_inc", {15'd0, sif.o_wrap}, 16'd0);
    drive1(0, 8'h00, 1, 0);
    check("b1_q_wrap", {8'd0, sif.o_q}, 16'h0000);
    check("b1_wrap_pulse", {15'd0, sif.o_wrap}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
